// File: rtl/generic_fifo_sc.sv
// Single-clock FIFO with a register-array store and a registered read port.
// Exposes exact and threshold flags, in both combinational and registered form, plus a coarse fill level.
module generic_fifo_sc #(
   parameter int dw = 8,
   parameter int aw = 8,
   parameter int n  = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [dw-1:0] din,
   input  logic          we,
   output logic [dw-1:0] dout,
   input  logic          re,
   output logic          full,
   output logic          empty,
   output logic          full_r,
   output logic          empty_r,
   output logic          full_n,
   output logic          empty_n,
   output logic          full_n_r,
   output logic          empty_n_r,
   output logic [1:0]    level
);

   localparam int           depth   = 1 << aw;
   localparam logic [aw:0]  cnt_max = (aw+1)'(depth);
   localparam logic [aw:0]  fn_thr  = (aw+1)'(depth - n);
   localparam logic [aw:0]  en_thr  = (aw+1)'(n);
   localparam logic [aw:0]  cnt_one = (aw+1)'(1);
   localparam logic [aw-1:0] ptr_one = aw'(1);

   logic [dw-1:0] mem [depth];
   logic [aw-1:0] wp;
   logic [aw-1:0] rp;
   logic [aw:0]   cnt;
   logic [aw:0]   cnt_next;
   logic          wr;
   logic          rd;

   assign wr = we & ~full;
   assign rd = re & ~empty;

   assign empty   = (cnt == '0);
   assign full    = (cnt == cnt_max);
   assign empty_n = (cnt < en_thr);
   assign full_n  = (cnt > fn_thr);
   assign level   = {2{cnt[aw]}} | cnt[aw-1:aw-2];

   // The registered flags are loaded from the next count so they track the combinational ones exactly.
   always_comb begin
      cnt_next = cnt;
      if (clr)
         cnt_next = '0;
      else if (wr && !rd)
         cnt_next = cnt + cnt_one;
      else if (rd && !wr)
         cnt_next = cnt - cnt_one;
   end

   always_ff @(posedge clk)
      if (wr && !clr)
         mem[wp] <= din;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wp        <= '0;
         rp        <= '0;
         cnt       <= '0;
         dout      <= '0;
         empty_r   <= 1'b1;
         empty_n_r <= 1'b1;
         full_r    <= 1'b0;
         full_n_r  <= 1'b0;
      end else begin
         cnt       <= cnt_next;
         empty_r   <= (cnt_next == '0);
         full_r    <= (cnt_next == cnt_max);
         empty_n_r <= (cnt_next < en_thr);
         full_n_r  <= (cnt_next > fn_thr);
         if (clr) begin
            wp <= '0;
            rp <= '0;
         end else begin
            if (wr)
               wp <= wp + ptr_one;
            if (rd) begin
               rp   <= rp + ptr_one;
               dout <= mem[rp];
            end
         end
      end

endmodule

// File: tb/tb_generic_fifo_sc.sv
// Directed bench for generic_fifo_sc (dw=8, aw=8, n=9) with a queue model of contents and occupancy.
module tb_generic_fifo_sc;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic [7:0] din;
   logic       we;
   logic       re;
   logic [7:0] dout;
   logic       full, empty, full_r, empty_r, full_n, empty_n, full_n_r, empty_n_r;
   logic [1:0] level;

   int         total = 0;
   int         bad   = 0;
   int         mc    = 0;
   logic [7:0] q[$];
   logic [7:0] exp_dout = 8'h00;

   always #5 clk = ~clk;

   generic_fifo_sc #(.dw(8), .aw(8), .n(9)) dut (
      .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .dout(dout), .re(re),
      .full(full), .empty(empty), .full_r(full_r), .empty_r(empty_r),
      .full_n(full_n), .empty_n(empty_n), .full_n_r(full_n_r), .empty_n_r(empty_n_r),
      .level(level)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Packed as {empty,empty_r,empty_n,empty_n_r,full,full_r,full_n,full_n_r,level}.
   function automatic logic [9:0] model_flags(input int c);
      logic [1:0] l;
      l = (c >= 192) ? 2'd3 : (c >= 128) ? 2'd2 : (c >= 64) ? 2'd1 : 2'd0;
      return {c == 0, c == 0, c < 9, c < 9, c == 256, c == 256, c >= 248, c >= 248, l};
   endfunction

   task automatic check_state(input string tag);
      check({tag, "_flags"},
            {22'd0, empty, empty_r, empty_n, empty_n_r, full, full_r, full_n, full_n_r, level},
            {22'd0, model_flags(mc)});
      check({tag, "_dout"}, {24'd0, dout}, {24'd0, exp_dout});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_cycle(input string tag, input logic w, input logic [7:0] d, input logic r);
      logic do_rd;
      logic do_wr;
      we    = w;
      din   = d;
      re    = r;
      do_rd = r && (mc > 0);
      do_wr = w && (mc < 256);
      tick;
      we = 1'b0;
      re = 1'b0;
      if (do_rd) begin
         exp_dout = q.pop_front();
         mc--;
      end
      if (do_wr) begin
         q.push_back(d);
         mc++;
      end
      check_state(tag);
   endtask

   initial begin
      logic [7:0] d;
      rst = 1'b1;
      clr = 1'b0;
      we  = 1'b0;
      re  = 1'b0;
      din = 8'h00;
      #2 rst = 1'b0;
      #1 check_state("reset_hold");
      tick;
      tick;
      rst = 1'b1;
      check_state("reset_release");

      // Read while empty must be ignored.
      do_cycle("idle_rd", 1'b0, 8'h00, 1'b1);
      check("idle_rd_dout", {24'd0, dout}, 32'h0);

      for (int k = 0; k < 10; k++) begin
         d = 8'($urandom_range(0, 255));
         do_cycle("single_wr", 1'b1, d, 1'b0);
         do_cycle("single_rd", 1'b0, 8'h00, 1'b1);
         check("single_rd_data", {24'd0, dout}, {24'd0, d});
         check("single_rd_empty", {31'd0, empty}, 32'd1);
      end

      for (int b = 2; b <= 4; b++)
         for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < b; j++)
               do_cycle("burst_wr", 1'b1, 8'($urandom_range(0, 255)), 1'b0);
            for (int j = 0; j < b; j++)
               do_cycle("burst_rd", 1'b0, 8'h00, 1'b1);
            check("burst_empty_n", {31'd0, empty_n}, 32'd1);
         end

      $display("[TB] fill phase");
      for (int i = 0; i < 256; i++) begin
         do_cycle("fill", 1'b1, 8'(i), 1'b0);
         if (i == 7)   check("fill8_empty_n",   {31'd0, empty_n},  32'd1);
         if (i == 8)   check("fill9_empty_n",   {31'd0, empty_n},  32'd0);
         if (i == 62)  check("fill63_level",    {30'd0, level},    32'd0);
         if (i == 63)  check("fill64_level",    {30'd0, level},    32'd1);
         if (i == 127) check("fill128_level",   {30'd0, level},    32'd2);
         if (i == 191) check("fill192_level",   {30'd0, level},    32'd3);
         if (i == 246) check("fill247_full_n",  {31'd0, full_n},   32'd0);
         if (i == 247) check("fill248_full_n",  {31'd0, full_n},   32'd1);
         if (i == 254) check("fill255_full",    {31'd0, full},     32'd0);
         if (i == 255) check("fill256_full_r",  {31'd0, full_r},   32'd1);
      end
      do_cycle("fill_over", 1'b1, 8'hAA, 1'b0);
      check("fill_over_full", {31'd0, full}, 32'd1);

      $display("[TB] drain phase");
      for (int i = 0; i < 256; i++) begin
         do_cycle("drain", 1'b0, 8'h00, 1'b1);
         check("drain_data", {24'd0, dout}, 32'(i));
         if (i == 7)   check("drain248_full_n",  {31'd0, full_n},  32'd1);
         if (i == 8)   check("drain247_full_n",  {31'd0, full_n},  32'd0);
         if (i == 246) check("drain9_empty_n",   {31'd0, empty_n}, 32'd0);
         if (i == 247) check("drain8_empty_n",   {31'd0, empty_n}, 32'd1);
         if (i == 255) check("drain0_empty",     {31'd0, empty},   32'd1);
      end
      do_cycle("drain_over", 1'b0, 8'h00, 1'b1);
      check("drain_over_dout", {24'd0, dout}, 32'hFF);

      $display("[TB] simultaneous and clear");
      for (int k = 0; k < 5; k++)
         do_cycle("pre5_wr", 1'b1, 8'(8'h10 + k), 1'b0);
      for (int k = 0; k < 3; k++)
         do_cycle("simul", 1'b1, 8'(8'h20 + k), 1'b1);
      check("simul_last_dout", {24'd0, dout}, 32'h12);
      do_cycle("simul_rd", 1'b0, 8'h00, 1'b1);
      do_cycle("simul_rd", 1'b0, 8'h00, 1'b1);
      check("simul_order", {24'd0, dout}, 32'h14);
      clr = 1'b1;
      we  = 1'b1;
      re  = 1'b1;
      din = 8'h77;
      tick;
      clr = 1'b0;
      we  = 1'b0;
      re  = 1'b0;
      mc  = 0;
      q.delete();
      check_state("clr");
      check("clr_level", {30'd0, level}, 32'd0);
      do_cycle("post_clr_rd", 1'b0, 8'h00, 1'b1);
      do_cycle("post_clr_wr", 1'b1, 8'h5A, 1'b0);
      do_cycle("post_clr_rd2", 1'b0, 8'h00, 1'b1);
      check("post_clr_data", {24'd0, dout}, 32'h5A);

      $display("[TB] async reset mid-burst");
      for (int k = 0; k < 4; k++)
         do_cycle("pre_rst_wr", 1'b1, 8'(8'h30 + k), 1'b0);
      we  = 1'b1;
      din = 8'h99;
      #2 rst = 1'b0;
      #1;
      mc = 0;
      q.delete();
      exp_dout = 8'h00;
      check_state("rst_async");
      we = 1'b0;
      tick;
      rst = 1'b1;
      check_state("rst_async_hold");
      do_cycle("post_rst_rd", 1'b0, 8'h00, 1'b1);
      do_cycle("post_rst_wr", 1'b1, 8'hC3, 1'b0);
      do_cycle("post_rst_rd2", 1'b0, 8'h00, 1'b1);
      check("post_rst_data", {24'd0, dout}, 32'hC3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
